// File: rtl/sync_sample_accum_pkg.sv
// Shared types and default sizing for the sync_sample_accum block.
// Holds the measurement FSM state encoding and default parameter values.
// No logic; imported by the top and available to any helper.
package sync_sample_accum_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_LOG2_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_sample_accum_sample_accumulator.sv
// Sign-extending sample accumulator with sample counter and terminal count.
// Latency: sum_nxt_o is combinational (acc + current sample); state updates on the en_i edge.
// Backpressure: none; clr_i has priority over en_i.
//
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   clr_i          zero accumulator and counter on next edge
//   en_i           add data_i and bump the counter on next edge
//   data_i         signed sample
//   sum_nxt_o      accumulator plus the sign-extended current sample
//   tc_o           counter is at N-1 (the sample being added now is the last)
module sample_accumulator #(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic                             en_i,
  input  logic        [DATA_W-1:0]         data_i,
  output logic signed [DATA_W+LOG2_N-1:0]  sum_nxt_o,
  output logic                             tc_o
);

  logic signed [DATA_W+LOG2_N-1:0] acc_q, acc_d;
  logic        [LOG2_N-1:0]        cnt_q, cnt_d;

  // The extra LOG2_N bits hold N full-scale samples exactly, so no saturation.
  assign sum_nxt_o = acc_q + $signed({{LOG2_N{data_i[DATA_W-1]}}, data_i});
  assign tc_o      = &cnt_q;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      acc_d = sum_nxt_o;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sync_sample_accum.sv
// Measurement controller: accumulates 2^LOG2_N ADC samples taken on i_sync and reports sum/mean.
// Latency: o_valid rises one cycle after the sync carrying the last sample.
// Backpressure: result held with o_valid until i_ready; syncs arriving meanwhile set sticky o_overrun.
//
// Ports:
//   i_clk, i_rst       clock, async active-high reset
//   i_sync, i_adc_data sample strobe and sample
//   i_start            begin a measurement (honoured only in IDLE)
//   i_ready            consumer accepts result
//   o_busy, o_valid    accumulating / result pending
//   o_sum, o_mean      signed sum and floor(sum / N)
//   o_overrun          sync seen while result pending; cleared by next accepted start
module sync_sample_accum
  import sync_sample_accum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_N = DEF_LOG2_N
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_sync,
  input  logic                             i_start,
  input  logic        [DATA_W-1:0]         i_adc_data,
  input  logic                             i_ready,
  output logic                             o_busy,
  output logic                             o_valid,
  output logic signed [DATA_W+LOG2_N-1:0]  o_sum,
  output logic signed [DATA_W-1:0]         o_mean,
  output logic                             o_overrun
);

  state_t                          state_q;
  logic                            busy_q, valid_q, overrun_q;
  logic signed [DATA_W+LOG2_N-1:0] sum_q;
  logic signed [DATA_W-1:0]        mean_q;

  logic                            acc_clr, acc_en, acc_tc;
  logic signed [DATA_W+LOG2_N-1:0] sum_nxt;

  // A sync coincident with the start edge lands in IDLE and is therefore not counted.
  assign acc_clr = (state_q == IDLE) && i_start;
  assign acc_en  = (state_q == ACC)  && i_sync;

  sample_accumulator #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_acc (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .clr_i     (acc_clr),
    .en_i      (acc_en),
    .data_i    (i_adc_data),
    .sum_nxt_o (sum_nxt),
    .tc_o      (acc_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      mean_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_q   <= ACC;
            busy_q    <= 1'b1;
            overrun_q <= 1'b0;
          end
        end
        ACC: begin
          if (i_sync && acc_tc) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            sum_q   <= sum_nxt;
            // Upper slice of the sum == arithmetic shift right by LOG2_N (floor).
            mean_q  <= sum_nxt[DATA_W+LOG2_N-1:LOG2_N];
          end
        end
        DONE: begin
          if (valid_q && i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (i_sync) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_sum     = sum_q;
  assign o_mean    = mean_q;
  assign o_overrun = overrun_q;

endmodule
